// File: rtl/game_screen_sequencer_pkg.sv
// rtl/game_screen_sequencer_pkg.sv - screen state and winner codes shared by sequencer, painter and decoder
package game_screen_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_WIN   = 2'd2
    } state_t;

    localparam logic [1:0] W_NONE = 2'd0;
    localparam logic [1:0] W_X    = 2'd1;
    localparam logic [1:0] W_O    = 2'd2;
    localparam logic [1:0] W_DRAW = 2'd3;

    // {ceWS, cePS, ceSS}; anything unknown falls back to the start screen so the enables stay one-hot
    function automatic logic [2:0] screen_enables(input state_t s);
        case (s)
            ST_PLAY: return 3'b010;
            ST_WIN:  return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/game_screen_sequencer_btn_debounce.sv
// rtl/game_screen_sequencer_btn_debounce.sv - button synchronizer and stable-level debouncer
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DB_W            = 20
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_clean
);

    logic            sync_1;
    logic            sync_2;
    logic [DB_W-1:0] stable_cnt;

    // The clean level only follows the synchronized input after it has differed for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            stable_cnt <= '0;
            btn_clean  <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            if (sync_2 == btn_clean) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_clean  <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_screen_sequencer.sv
// rtl/game_screen_sequencer.sv - frame-aligned start/play/winner screen controller for the TicTacToe display
module game_screen_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int WIN_SECONDS     = 5,
    parameter int DB_W            = 20
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       vsync,
    input  logic       clk1Hz,
    input  logic       game_over,
    input  logic [1:0] winner_in,
    output logic       ceSS,
    output logic       cePS,
    output logic       ceWS,
    output logic       game_clear,
    output logic [1:0] winner,
    output logic       pending
);
    import game_screen_sequencer_pkg::*;

    localparam int SEC_W = $clog2(WIN_SECONDS + 2);

    logic             btn_clean;
    logic             btn_clean_q;
    logic             press;
    logic             vs_sync_1, vs_sync_2, vs_prev;
    logic             hz_sync_1, hz_sync_2, hz_prev;
    logic             frame_tick;
    logic             hz_tick;
    logic             timeout;
    logic [SEC_W-1:0] sec_cnt;
    state_t           state_q, state_d, state_prev;
    state_t           target_q, target_d, req_target;
    logic             pending_d;
    logic             req;
    logic             illegal;
    logic             latch_winner;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
    ) u_btn_debounce (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .btn_raw   (start_btn),
        .btn_clean (btn_clean)
    );

    assign frame_tick = vs_sync_2 & ~vs_prev;
    assign hz_tick    = hz_sync_2 & ~hz_prev;
    assign timeout    = (state_q == ST_WIN) && (sec_cnt == SEC_W'(WIN_SECONDS));

    // Requests only arm a pending change; the state itself moves on a frame boundary
    always_comb begin
        state_d      = state_q;
        pending_d    = pending;
        target_d     = target_q;
        latch_winner = 1'b0;
        req          = 1'b0;
        req_target   = ST_START;
        illegal      = 1'b0;
        case (state_q)
            ST_START: if (press) begin
                req        = 1'b1;
                req_target = ST_PLAY;
            end
            ST_PLAY: if (game_over) begin
                req        = 1'b1;
                req_target = ST_WIN;
            end
            ST_WIN: if (press || timeout) begin
                req        = 1'b1;
                req_target = ST_START;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            state_d   = ST_START;
            pending_d = 1'b0;
            target_d  = ST_START;
        end else if (pending) begin
            if (frame_tick) begin
                state_d   = target_q;
                pending_d = 1'b0;
            end
        end else if (req) begin
            pending_d    = 1'b1;
            target_d     = req_target;
            latch_winner = (state_q == ST_PLAY);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            btn_clean_q        <= 1'b0;
            press              <= 1'b0;
            vs_sync_1          <= 1'b0;
            vs_sync_2          <= 1'b0;
            vs_prev            <= 1'b0;
            hz_sync_1          <= 1'b0;
            hz_sync_2          <= 1'b0;
            hz_prev            <= 1'b0;
            sec_cnt            <= '0;
            state_q            <= ST_START;
            state_prev         <= ST_START;
            target_q           <= ST_START;
            pending            <= 1'b0;
            winner             <= W_NONE;
            game_clear         <= 1'b0;
            {ceWS, cePS, ceSS} <= 3'b001;
        end else begin
            btn_clean_q <= btn_clean;
            press       <= btn_clean & ~btn_clean_q;
            vs_sync_1   <= vsync;
            vs_sync_2   <= vs_sync_1;
            vs_prev     <= vs_sync_2;
            hz_sync_1   <= clk1Hz;
            hz_sync_2   <= hz_sync_1;
            hz_prev     <= hz_sync_2;

            state_q            <= state_d;
            state_prev         <= state_q;
            target_q           <= target_d;
            pending            <= pending_d;
            {ceWS, cePS, ceSS} <= screen_enables(state_d);
            game_clear         <= (state_q == ST_PLAY) && (state_prev != ST_PLAY);
            if (latch_winner) begin
                winner <= winner_in;
            end

            // Ticks stop counting once the return to START is already pending
            if (state_q != ST_WIN) begin
                sec_cnt <= '0;
            end else if (hz_tick && !pending) begin
                sec_cnt <= sec_cnt + 1'b1;
            end
        end
    end

endmodule
